fp_addsub_unit: RTL and testbench

FP_ADDSUB_UNIT -- requirements
Module: fp_addsub_unit

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_align_shift.sv | 23 ++
 rtl/fp_addsub_unit.sv | 203 ++++++++++++++++++++
 tb/tb_fp_addsub_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FSM state type and exponent/GRS constants for fp_addsub_unit
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam int GRS_W = 3;

    function automatic int exp_all_ones(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic int exp_zero(input int ew);
        return ew * 0;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// rtl/fp_align_shift.sv - right shifter that ORs every shifted-out bit into the sticky LSB
module fp_align_shift
    import fp_pkg::*;
#(
    parameter int MAN_W = 23,
    localparam int SIG_W = MAN_W + 2 + GRS_W,
    localparam int SH_W  = $clog2(SIG_W)
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [SH_W-1:0]  amt,
    output logic [SIG_W-1:0] shifted
);

    logic [SIG_W-1:0] mask;
    logic             sticky;

    always_comb begin
        mask    = (SIG_W'(1) << amt) - SIG_W'(1);
        sticky  = |(sig & mask);
        shifted = (sig >> amt) | {{(SIG_W-1){1'b0}}, sticky};
    end

endmodule

// File: rtl/fp_addsub_unit.sv
// rtl/fp_addsub_unit.sv - multi-cycle floating-point adder/subtractor (denormals flushed)
// FP_ADDSUB_ROUND_EN selects round-to-nearest-even; otherwise the ROUND stage truncates.
module fp_addsub_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   zero
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 2 + GRS_W;
    localparam int SH_W  = $clog2(SIG_W);
    localparam int HID   = MAN_W + GRS_W;
    localparam int CRY   = HID + 1;
    localparam logic [EXP_W-1:0] EXP_ONES  = EXP_W'(exp_all_ones(EXP_W));
    localparam logic [EXP_W-1:0] EXP_ZERO  = EXP_W'(exp_zero(EXP_W));
    localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(MAN_W + GRS_W + 1);

    state_t state, state_next;

    logic [W-1:0]     a_r, b_r, res_q;
    logic [SIG_W-1:0] big_sig, small_sig, sig_q;
    logic [EXP_W-1:0] exp_q;
    logic             sign_q, sub_q, ovf_q, unf_q, zero_q;

    logic [EXP_W-1:0] ea, eb, e_big, e_small, diff, exp_dec;
    logic             special, a_big, spec_sign, s_big;
    logic [SIG_W-1:0] sig_a, sig_b, big_raw, small_raw, small_shifted, sum, rsh;
    logic [SH_W-1:0]  amt;
    logic             inc;
    logic [MAN_W+1:0] rnd;
    logic [EXP_W:0]   exp_rnd;
    logic [MAN_W-1:0] man_rnd;
    logic             rnd_ovf;

    // Operand decode and ordering; a flushed operand contributes a zero significand.
    always_comb begin
        ea        = a_r[W-2:MAN_W];
        eb        = b_r[W-2:MAN_W];
        special   = (ea == EXP_ONES) || (eb == EXP_ONES);
        spec_sign = (ea == EXP_ONES) ? a_r[W-1] : b_r[W-1];
        a_big     = a_r[W-2:0] >= b_r[W-2:0];
        sig_a     = (ea == EXP_ZERO) ? '0 : {2'b01, a_r[MAN_W-1:0], {GRS_W{1'b0}}};
        sig_b     = (eb == EXP_ZERO) ? '0 : {2'b01, b_r[MAN_W-1:0], {GRS_W{1'b0}}};
        big_raw   = a_big ? sig_a : sig_b;
        small_raw = a_big ? sig_b : sig_a;
        e_big     = a_big ? ea : eb;
        e_small   = a_big ? eb : ea;
        s_big     = a_big ? a_r[W-1] : b_r[W-1];
        diff      = e_big - e_small;
        amt       = (diff > SHIFT_SAT) ? SH_W'(SHIFT_SAT) : SH_W'(diff);
    end

    fp_align_shift #(.MAN_W(MAN_W)) u_align (
        .sig     (small_raw),
        .amt     (amt),
        .shifted (small_shifted)
    );

    assign sum     = sub_q ? (big_sig - small_sig) : (big_sig + small_sig);
    assign rsh     = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
    assign exp_dec = exp_q - EXP_W'(1);

`ifdef FP_ADDSUB_ROUND_EN
    assign inc = sig_q[GRS_W-1] & (sig_q[GRS_W-2] | sig_q[0] | sig_q[GRS_W]);
`else
    assign inc = 1'b0;
`endif

    always_comb begin
        rnd     = {1'b0, sig_q[HID:GRS_W]} + {{(MAN_W+1){1'b0}}, inc};
        exp_rnd = {1'b0, exp_q} + {{EXP_W{1'b0}}, rnd[MAN_W+1]};
        man_rnd = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        rnd_ovf = exp_rnd >= {1'b0, EXP_ONES};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ALIGN;
            end
            ALIGN:   state_next = special ? DONE : ADD;
            ADD:     state_next = (sum == '0) ? DONE : NORM;
            NORM: begin
                if (sig_q[CRY] || sig_q[HID]) state_next = ROUND;
                else if (exp_dec == EXP_ZERO) state_next = DONE;
            end
            ROUND:   state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            big_sig   <= '0;
            small_sig <= '0;
            sig_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r    <= a;
                    b_r    <= {b[W-1] ^ op, b[W-2:0]};
                    ovf_q  <= 1'b0;
                    unf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end
                ALIGN: begin
                    if (special) begin
                        res_q <= {spec_sign, EXP_ONES, {MAN_W{1'b0}}};
                        ovf_q <= 1'b1;
                    end else begin
                        big_sig   <= big_raw;
                        small_sig <= small_shifted;
                        exp_q     <= e_big;
                        sign_q    <= s_big;
                        sub_q     <= a_r[W-1] ^ b_r[W-1];
                    end
                end
                ADD: begin
                    if (sum == '0) begin
                        res_q  <= '0;
                        zero_q <= 1'b1;
                    end else begin
                        sig_q <= sum;
                    end
                end
                NORM: begin
                    if (sig_q[CRY]) begin
                        sig_q <= rsh;
                        exp_q <= exp_q + EXP_W'(1);
                    end else if (!sig_q[HID]) begin
                        if (exp_dec == EXP_ZERO) begin
                            res_q <= {sign_q, {(W-1){1'b0}}};
                            unf_q <= 1'b1;
                        end else begin
                            sig_q <= sig_q << 1;
                            exp_q <= exp_dec;
                        end
                    end
                end
                ROUND: begin
                    if (rnd_ovf) begin
                        res_q <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                        ovf_q <= 1'b1;
                    end else begin
                        res_q <= {sign_q, exp_rnd[EXP_W-1:0], man_rnd};
                    end
                end
                DONE: begin
                    // Outputs load on the first DONE cycle and then hold until accepted.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= res_q;
                        overflow  <= ovf_q;
                        underflow <= unf_q;
                        zero      <= zero_q;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// tb/tb_fp_addsub_unit.sv - scoreboard bench for fp_addsub_unit (EXP_W=8, MAN_W=23)
module tb_fp_addsub_unit;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op, out_valid, out_ready;
    logic        overflow, underflow, zero;
    logic [31:0] a, b, result;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                        input logic [31:0] er, input logic [2:0] ef, input int el);
        exp_t e;
        int   n = 0;
        a = av; b = bv; op = opv; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = er; e.flags = ef; e.lat = el;
        sb.push_back(e);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_handshake got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if ({result, overflow, underflow, zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got result=%h flags=%b%b%b required 0", result, overflow, underflow, zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [31:0] ta[12] = '{32'h3F800000, 32'h3FC00000, 32'h7F7FFFFF, 32'h3F800000,
                                32'h40000000, 32'h3F800000, 32'hBF800000, 32'h7F800000,
                                32'h3F800000, 32'h7F800000, 32'h00800000, 32'h00400000};
        logic [31:0] tb_[12] = '{32'h3F800000, 32'h3FC00000, 32'h7F7FFFFF, 32'h3F7FFFFF,
                                 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                                 32'h7F800000, 32'hFF800000, 32'h00C00000, 32'h3F800000};
        logic        to[12]  = '{0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0};
        logic [31:0] tr[12]  = '{32'h40000000, 32'h00000000, 32'h7F800000, 32'h33800000,
                                 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F800000,
                                 32'hFF800000, 32'h7F800000, 32'h80000000, 32'h3F800000};
        logic [2:0]  tf[12]  = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000,
                                 3'b001, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000};
        int          tl[12]  = '{5, -1, 5, 29, 6, 5, -1, -1, -1, -1, -1, 5};
        exp_t e;
        int   lat;
        for (int i = 0; i < 12; i++) begin
            send(ta[i], tb_[i], to[i], tr[i], tf[i], tl[i]);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL arith%0d_timeout out_valid=%b required 1", i, out_valid);
            end
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL arith%0d_result got %h required %h", i, result, e.res);
            end
            checks++;
            if ({overflow, underflow, zero} !== e.flags) begin
                errors++;
                $display("FAIL arith%0d_flags got %b%b%b required %b", i, overflow, underflow, zero, e.flags);
            end
            if (e.lat >= 0) begin
                checks++;
                if (lat != e.lat) begin
                    errors++;
                    $display("FAIL arith%0d_latency got %0d required %0d", i, lat, e.lat);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rounding();
        logic [31:0] ta[4]  = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF};
        logic [31:0] tb_[4] = '{32'h33C00000, 32'h33800000, 32'h33800000, 32'h33C00000};
`ifdef FP_ADDSUB_ROUND_EN
        logic [31:0] tr[4]  = '{32'h3F800001, 32'h3F800000, 32'h3F800002, 32'h40000000};
`else
        logic [31:0] tr[4]  = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF};
`endif
        exp_t e;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb_[i], 1'b0, tr[i], 3'b000, 5);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL round%0d_result got %h required %h", i, result, e.res);
            end
            checks++;
            if ({overflow, underflow, zero} !== e.flags || lat != e.lat) begin
                errors++;
                $display("FAIL round%0d_flags_lat got %b%b%b/%0d required %b/%0d",
                         i, overflow, underflow, zero, lat, e.flags, e.lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5);
        wait_out(lat);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || result !== e.res ||
                {overflow, underflow, zero} !== e.flags) begin
                errors++;
                $display("FAIL hold%0d got v=%b rdy=%b res=%h flags=%b%b%b required 1 0 %h %b",
                         i, out_valid, in_ready, result, overflow, underflow, zero, e.res, e.flags);
            end
        end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL handshake_cycle_in_ready got %b required 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_handshake got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        send(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 29);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_discard got out_valid=%b required 0", out_valid);
        end
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 5);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (result !== e.res || lat != e.lat) begin
            errors++;
            $display("FAIL reset_recover got %h/%0d required %h/%0d", result, lat, e.res, e.lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta[3]  = '{32'hC0000000, 32'h3F800000, 32'h41200000};
        logic [31:0] tb_[3] = '{32'h3F800000, 32'hBF800000, 32'h41200000};
        logic        to[3]  = '{0, 1, 1};
        logic [31:0] tr[3]  = '{32'hBF800000, 32'h40000000, 32'h00000000};
        logic [2:0]  tf[3]  = '{3'b000, 3'b000, 3'b001};
        exp_t e;
        int   lat;
        for (int i = 0; i < 3; i++) begin
            send(ta[i], tb_[i], to[i], tr[i], tf[i], 0);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (result !== e.res || {overflow, underflow, zero} !== e.flags) begin
                errors++;
                $display("FAIL b2b%0d got %h/%b%b%b required %h/%b",
                         i, result, overflow, underflow, zero, e.res, e.flags);
            end
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d_ready got %b required 1", i, in_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; a = '0; b = '0;
        test_reset();
        test_arith();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
